// File: rtl/dm_cache_line_fill.sv
// dm_cache_line_fill: AXI4 read-burst refill engine for a direct-mapped cache.
// Takes one line miss, issues one AR burst, streams beats to the data array,
// then pulses done_o with err_o.
// Ports: clk, rst (async, active-high); req_valid_i/req_ready_o/req_addr_i
//   miss request; fill_valid_o/fill_data_o/fill_idx_o word strobe;
//   done_o/err_o completion; m_axi_ar* / m_axi_r* AXI4 read channels.
// Config macro: DM_FILL_WRAP_EN selects critical-word-first WRAP bursts;
//   undefined gives line-aligned INCR bursts starting at word 0.
module dm_cache_line_fill #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    output logic                          fill_valid_o,
    output logic [DATA_WIDTH-1:0]         fill_data_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = BYTE_W + IDX_W;
    localparam int CNT_W  = IDX_W + 1;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
        ~((ADDR_WIDTH'(1) << BYTE_W) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_LAST,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;
    logic                    r_fill_valid;
    logic [DATA_WIDTH-1:0]   r_fill_data;
    logic [IDX_W-1:0]        r_fill_idx;
    logic                    r_done;
    logic                    r_err_o;

    logic                    w_beat;
    logic                    w_in_line;
    logic                    w_short;
    logic [ADDR_WIDTH-1:0]   w_araddr;
    logic [IDX_W-1:0]        w_idx0;

`ifdef DM_FILL_WRAP_EN
    assign w_araddr      = req_addr_i & WORD_MASK;
    assign w_idx0        = req_addr_i[OFF_W-1:BYTE_W];
    assign m_axi_arburst = 2'b10;
`else
    assign w_araddr      = req_addr_i & LINE_MASK;
    assign w_idx0        = '0;
    assign m_axi_arburst = 2'b01;
`endif

    assign m_axi_arlen  = 8'(LINE_WORDS - 1);
    assign m_axi_arsize = 3'(BYTE_W);

    assign req_ready_o   = (r_state == S_IDLE);
    assign m_axi_rready  = (r_state == S_RD);
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign fill_valid_o  = r_fill_valid;
    assign fill_data_o   = r_fill_data;
    assign fill_idx_o    = r_fill_idx;
    assign done_o        = r_done;
    assign err_o         = r_err_o;

    assign w_beat    = m_axi_rvalid & m_axi_rready;
    // r_cnt saturates at LINE_WORDS, so extra beats keep w_in_line low.
    assign w_in_line = (r_cnt < CNT_W'(LINE_WORDS));
    // rlast arriving while fewer than LINE_WORDS-1 beats already taken.
    assign w_short   = (r_cnt < CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_araddr     <= '0;
            r_arvalid    <= 1'b0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_fill_idx   <= '0;
            r_done       <= 1'b0;
            r_err_o      <= 1'b0;
        end else begin
            r_fill_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err_o      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_araddr  <= w_araddr;
                        r_arvalid <= 1'b1;
                        r_idx     <= w_idx0;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (w_beat) begin
                        if (w_in_line) begin
                            r_fill_valid <= 1'b1;
                            r_fill_data  <= m_axi_rdata;
                            r_fill_idx   <= r_idx;
                            r_idx        <= r_idx + 1'b1;
                            r_cnt        <= r_cnt + 1'b1;
                        end
                        if (!w_in_line || (m_axi_rresp != 2'b00) ||
                            (m_axi_rlast && w_short)) begin
                            r_err <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            r_state <= S_LAST;
                        end
                    end
                end
                // Last fill strobe is on the wire this cycle; report next.
                S_LAST: begin
                    r_done  <= 1'b1;
                    r_err_o <= r_err;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_line_fill.sv
// tb_dm_cache_line_fill: directed self-checking bench for dm_cache_line_fill.
// Drives requests and AXI R beats by hand, records fill strobes and done.
module tb_dm_cache_line_fill;

`ifdef DM_FILL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic [1:0]  fill_idx;
    logic        done;
    logic        err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;

    int          n;
    logic [1:0]  f_idx[16];
    logic [31:0] f_data[16];
    int          d_cnt;
    logic        d_err;
    int          d_cyc;

    dm_cache_line_fill dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .fill_valid_o  (fill_valid),
        .fill_data_o   (fill_data),
        .fill_idx_o    (fill_idx),
        .done_o        (done),
        .err_o         (err),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (fill_valid && n < 16) begin
                f_idx[n]  = fill_idx;
                f_data[n] = fill_data;
                n = n + 1;
            end
            if (done) begin
                d_cnt = d_cnt + 1;
                d_err = err;
                d_cyc = cyc;
            end
        end
    end

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & 32'hFFFF_FFF0;
    endfunction

    function automatic int start_of(input logic [31:0] a);
        return WRAP ? int'(a[3:2]) : 0;
    endfunction

    function automatic logic [31:0] exp_ar(input logic [31:0] a);
        return WRAP ? (a & 32'hFFFF_FFFC) : line_of(a);
    endfunction

    task automatic clear_mon();
        n = 0;
        d_cnt = 0;
        d_err = 1'b0;
        d_cyc = 0;
    endtask

    task automatic send_req(input logic [31:0] a);
        @(negedge clk);
        req_addr = a;
        req_valid = 1'b1;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rready();
        @(negedge clk);
        for (int i = 0; i < 50 && !rready; i++) @(negedge clk);
        if (!rready) begin
            checks++;
            errors++;
            $display("FAIL rready_timeout got 0 exp 1");
        end
    endtask

    task automatic wait_done();
        @(negedge clk);
        #1;
        for (int i = 0; i < 100 && d_cnt == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (d_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got 0 exp 1");
        end
    endtask

    // pat bit c set means a beat is offered in cycle c; past plen, always.
    task automatic send_beats(input logic [31:0] line, input int start,
                              input int nb, input int errb,
                              input logic [15:0] pat, input int plen);
        int k = 0;
        int c = 0;
        while (k < nb) begin
            if (c >= plen || pat[c]) begin
                rvalid = 1'b1;
                rdata  = line + 32'(((start + k) % 4) * 4);
                rresp  = (k == errb) ? 2'b10 : 2'b00;
                rlast  = (k == nb - 1);
                k++;
            end else begin
                rvalid = 1'b0;
                rresp  = 2'b00;
                rlast  = 1'b0;
            end
            c++;
            @(negedge clk);
        end
        rvalid = 1'b0;
        rresp  = 2'b00;
        rlast  = 1'b0;
    endtask

    task automatic check_fills(input string tag, input logic [31:0] a,
                               input int cnt);
        logic [31:0] ln;
        logic [1:0]  ei;
        ln = line_of(a);
        checks++;
        if (n !== cnt) begin
            errors++;
            $display("FAIL %s_fill_count got %0d exp %0d", tag, n, cnt);
        end
        for (int k = 0; k < cnt; k++) begin
            ei = 2'((start_of(a) + k) % 4);
            checks++;
            if (f_idx[k] !== ei || f_data[k] !== ln + 32'(ei) * 4) begin
                errors++;
                $display("FAIL %s_fill%0d got idx %0d data %h exp idx %0d data %h",
                         tag, k, f_idx[k], f_data[k], ei, ln + 32'(ei) * 4);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, arvalid, rready, fill_valid, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 100000",
                     {req_ready, arvalid, rready, fill_valid, done, err});
        end
        checks++;
        if (araddr !== 32'h0 || fill_data !== 32'h0 || fill_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got ar %h d %h i %0d exp 0",
                     araddr, fill_data, fill_idx);
        end
        checks++;
        if (arlen !== 8'd3 || arsize !== 3'd2 ||
            arburst !== (WRAP ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL ar_const got len %0d size %0d burst %0d exp 3 2 %0d",
                     arlen, arsize, arburst, WRAP ? 2 : 1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] a;
        a = WRAP ? 32'h28 : 32'h14;
        clear_mon();
        send_req(a);
        checks++;
        if (arvalid !== 1'b1 || araddr !== exp_ar(a)) begin
            errors++;
            $display("FAIL basic_ar got v %b a %h exp 1 %h",
                     arvalid, araddr, exp_ar(a));
        end
        wait_rready();
        send_beats(line_of(a), start_of(a), 4, -1, 16'h0, 0);
        wait_done();
        check_fills("basic", a, 4);
        checks++;
        if (d_cyc !== acc_cyc + 7) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d",
                     d_cyc - acc_cyc, 7);
        end
        checks++;
        if (d_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got %b exp 0", d_err);
        end
    endtask

    task automatic test_ar_stall();
        logic [31:0] a;
        a = 32'h104;
        arready = 1'b0;
        clear_mon();
        send_req(a);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (arvalid !== 1'b1 || araddr !== exp_ar(a)) begin
                errors++;
                $display("FAIL stall_ar%0d got v %b a %h exp 1 %h",
                         i, arvalid, araddr, exp_ar(a));
            end
            if (i == 1) begin
                req_valid = 1'b1;
                req_addr = 32'h200;
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready got %b exp 0", req_ready);
                end
            end
            if (i == 3) req_valid = 1'b0;
        end
        arready = 1'b1;
        wait_rready();
        send_beats(line_of(a), start_of(a), 4, -1, 16'h0, 0);
        wait_done();
        repeat (4) @(negedge clk);
        check_fills("stall", a, 4);
        checks++;
        if (d_cnt !== 1 || d_err !== 1'b0 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got cnt %0d err %b arv %b exp 1 0 0",
                     d_cnt, d_err, arvalid);
        end
    endtask

    task automatic test_rvalid_gaps();
        logic [31:0] a;
        a = 32'h340;
        clear_mon();
        send_req(a);
        wait_rready();
        send_beats(line_of(a), start_of(a), 4, -1, 16'b1100101, 7);
        wait_done();
        repeat (4) @(negedge clk);
        check_fills("gaps", a, 4);
        checks++;
        if (d_cnt !== 1 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done got cnt %0d err %b exp 1 0", d_cnt, d_err);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] a;
        a = 32'h58;
        clear_mon();
        send_req(a);
        wait_rready();
        send_beats(line_of(a), start_of(a), 4, 1, 16'h0, 0);
        wait_done();
        check_fills("slverr", a, 4);
        checks++;
        if (d_err !== 1'b1) begin
            errors++;
            $display("FAIL slverr_err got %b exp 1", d_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        a = 32'h80;
        clear_mon();
        send_req(a);
        wait_rready();
        send_beats(line_of(a), start_of(a), 3, -1, 16'h0, 0);
        wait_done();
        check_fills("short", a, 3);
        checks++;
        if (d_err !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL short_done got err %b rdy %b exp 1 0", d_err, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b exp 1", req_ready);
        end
        a = 32'h4C;
        clear_mon();
        req_addr = a;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== exp_ar(a)) begin
            errors++;
            $display("FAIL b2b_ar got v %b a %h exp 1 %h",
                     arvalid, araddr, exp_ar(a));
        end
        wait_rready();
        send_beats(line_of(a), start_of(a), 4, -1, 16'h0, 0);
        wait_done();
        check_fills("b2b", a, 4);
        checks++;
        if (d_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err got %b exp 0", d_err);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] a;
        a = 32'h94;
        clear_mon();
        send_req(a);
        wait_rready();
        send_beats(line_of(a), start_of(a), 5, -1, 16'h0, 0);
        wait_done();
        check_fills("over", a, 4);
        checks++;
        if (d_err !== 1'b1) begin
            errors++;
            $display("FAIL over_err got %b exp 1", d_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        a = 32'h28;
        clear_mon();
        send_req(a);
        wait_rready();
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        rresp = 2'b00;
        rlast = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, arvalid, rready, fill_valid, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL midrst_ctrl got %b exp 100000",
                     {req_ready, arvalid, rready, fill_valid, done, err});
        end
        checks++;
        if (araddr !== 32'h0 || fill_data !== 32'h0 || fill_idx !== 2'd0) begin
            errors++;
            $display("FAIL midrst_data got ar %h d %h i %0d exp 0",
                     araddr, fill_data, fill_idx);
        end
        rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        checks++;
        if (n !== 0 || d_cnt !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle got fills %0d done %0d rdy %b exp 0 0 1",
                     n, d_cnt, req_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'h0;
        arready = 1'b1;
        rdata = 32'h0;
        rresp = 2'b00;
        rlast = 1'b0;
        rvalid = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_ar_stall();
        test_rvalid_gaps();
        test_slverr();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
